resp_bus_arbiter: RTL and testbench

// - Owns the shared coherence response bus: collects resp_bus_req/resp_bus_tx from every L1 and L2 coherence agent.
// - Grants one agent at a time with a round-robin policy and broadcasts the winner's resp_msg_t on resp_bus_msg for one cycle.
// - Holds the bus while the owner asserts busy, and releases it with an error flag on hold timeout.

---
 rtl/cache_types.sv | 19 +
 rtl/rr_pick.sv | 36 +++
 rtl/resp_bus_arbiter.sv | 116 +++++++++++
 tb/tb_resp_bus_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_types.sv
// Shared coherence types: response-bus message format and the response-bus arbiter state encoding.
package cache_types;

  typedef enum logic [1:0] {
    RA_IDLE,
    RA_BCAST,
    RA_HOLD
  } resp_arb_state_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  msg_type;
    logic [3:0]  source;
    logic [3:0]  destination;
    logic [31:0] addr;
    logic [31:0] data;
  } resp_msg_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: lowest requester at or after ptr_i, wrapping modulo N.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [2*N-1:0] wide;
  logic [N-1:0]   rot;
  logic [IW:0]    sum;

  // rot[i] is the request of agent (ptr_i + i) mod N.
  assign wide = {req_i, req_i} >> ptr_i;
  assign rot  = wide[N-1:0];

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, ptr_i} + (IW+1)'(i);
        if (sum >= (IW+1)'(N)) begin
          sum = sum - (IW+1)'(N);
        end
        found_o = 1'b1;
        idx_o   = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/resp_bus_arbiter.sv
// Coherence response-bus arbiter: round-robin grant, one-cycle broadcast, optional owner hold with timeout.
module resp_bus_arbiter
  import cache_types::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_HOLD = 64,
  localparam int CNT_W    = $clog2(MAX_HOLD + 1),
  localparam int IW       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  resp_msg_t [NUM_REQ-1:0]       tx,
  input  logic [NUM_REQ-1:0]            busy,
  output logic [NUM_REQ-1:0]            gnt,
  output resp_msg_t                     resp_bus_msg,
  output logic [IW-1:0]                 owner,
  output logic                          hold_timeout,
  output resp_arb_state_t               state_dbg
);

  // Handshake: an agent holds req[k] high until it sees gnt[k]; gnt is a one-cycle pulse
  // coincident with resp_bus_msg.valid. busy is only looked at for the current owner.

  resp_arb_state_t  state_q, state_d;
  resp_msg_t        msg_q, msg_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [NUM_REQ-1:0] owner_oh;
  logic [NUM_REQ-1:0] pick_req;
  logic               pick_found;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      nxt_ptr;

  assign owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
  // The owner's req is still high while its grant is on the bus, so exclude it from re-arbitration.
  assign pick_req = (state_q == RA_BCAST) ? (req & ~owner_oh) : req;
  assign nxt_ptr  = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .req_i   (pick_req),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d            = state_q;
    msg_d              = msg_q;
    owner_d            = owner_q;
    rr_ptr_d           = rr_ptr_q;
    hold_cnt_d         = hold_cnt_q;
    gnt                = '0;
    resp_bus_msg       = msg_q;
    resp_bus_msg.valid = 1'b0;
    hold_timeout       = 1'b0;
    unique case (state_q)
      RA_IDLE: begin
        if (pick_found) begin
          msg_d    = tx[pick_idx];
          owner_d  = pick_idx;
          rr_ptr_d = nxt_ptr;
          state_d  = RA_BCAST;
        end
      end
      RA_BCAST: begin
        gnt                = owner_oh;
        resp_bus_msg.valid = 1'b1;
        if (busy[owner_q]) begin
          hold_cnt_d = '0;
          state_d    = RA_HOLD;
        end else if (pick_found) begin
          msg_d    = tx[pick_idx];
          owner_d  = pick_idx;
          rr_ptr_d = nxt_ptr;
          state_d  = RA_BCAST;
        end else begin
          state_d = RA_IDLE;
        end
      end
      RA_HOLD: begin
        if (!busy[owner_q]) begin
          state_d = RA_IDLE;
        end else if (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          hold_timeout = 1'b1;
          state_d      = RA_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RA_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RA_IDLE;
      msg_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      msg_q      <= msg_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign owner     = owner_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_resp_bus_arbiter.sv
// Directed bench for resp_bus_arbiter: grant order, broadcast content, hold, timeout and reset behaviour.
module tb_resp_bus_arbiter;
  import cache_types::*;

  logic                clk;
  logic                rst;
  logic [3:0]          req;
  resp_msg_t [3:0]     tx;
  logic [3:0]          busy;
  logic [3:0]          gnt;
  resp_msg_t           resp_bus_msg;
  logic [1:0]          owner;
  logic                hold_timeout;
  resp_arb_state_t     state_dbg;

  int checks = 0;
  int errors = 0;

  resp_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .tx           (tx),
    .busy         (busy),
    .gnt          (gnt),
    .resp_bus_msg (resp_bus_msg),
    .owner        (owner),
    .hold_timeout (hold_timeout),
    .state_dbg    (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected broadcast for agent k: its tx with valid forced high.
  function automatic resp_msg_t bcast(input int k);
    resp_msg_t m;
    m       = tx[k];
    m.valid = 1'b1;
    return m;
  endfunction

  function automatic resp_msg_t held(input int k);
    resp_msg_t m;
    m       = tx[k];
    m.valid = 1'b0;
    return m;
  endfunction

  // Scoreboard checks
  task automatic chk_gnt(input string tag, input logic [3:0] exp);
    checks++;
    assert (gnt === exp) else begin
      errors++;
      $error("FAIL %s gnt: observed %b expected %b", tag, gnt, exp);
    end
  endtask

  task automatic chk_msg(input string tag, input resp_msg_t exp);
    checks++;
    assert (resp_bus_msg === exp) else begin
      errors++;
      $error("FAIL %s msg: observed %h expected %h", tag, resp_bus_msg, exp);
    end
  endtask

  task automatic chk_valid(input string tag, input logic exp);
    checks++;
    assert (resp_bus_msg.valid === exp) else begin
      errors++;
      $error("FAIL %s valid: observed %b expected %b", tag, resp_bus_msg.valid, exp);
    end
  endtask

  task automatic chk_owner(input string tag, input logic [1:0] exp);
    checks++;
    assert (owner === exp) else begin
      errors++;
      $error("FAIL %s owner: observed %0d expected %0d", tag, owner, exp);
    end
  endtask

  task automatic chk_to(input string tag, input logic exp);
    checks++;
    assert (hold_timeout === exp) else begin
      errors++;
      $error("FAIL %s hold_timeout: observed %b expected %b", tag, hold_timeout, exp);
    end
  endtask

  task automatic chk_state(input string tag, input resp_arb_state_t exp);
    checks++;
    assert (state_dbg === exp) else begin
      errors++;
      $error("FAIL %s state: observed %0d expected %0d", tag, state_dbg, exp);
    end
  endtask

  task automatic chk_bcast(input string tag, input int k);
    logic [3:0] oh;
    oh = 4'b0001 << k;
    chk_gnt(tag, oh);
    chk_msg(tag, bcast(k));
    chk_owner(tag, 2'(k));
    chk_state(tag, RA_BCAST);
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    busy = '0;
    for (int k = 0; k < 4; k++) begin
      tx[k].valid       = 1'b0;
      tx[k].msg_type    = 4'(k + 1);
      tx[k].source      = 4'(k);
      tx[k].destination = 4'(3 - k);
      tx[k].addr        = 32'h4000_0000 + 32'(k * 64);
      tx[k].data        = 32'hA5A5_0000 ^ 32'(k * 32'h1111);
    end
    tick();
    tick();
    rst = 1'b0;

    // Reset values
    chk_gnt("reset", 4'b0000);
    chk_msg("reset", '0);
    chk_owner("reset", 2'd0);
    chk_to("reset", 1'b0);
    chk_state("reset", RA_IDLE);

    // Single requester, one-cycle latency
    req = 4'b0100;
    chk_gnt("single_t0", 4'b0000);
    tick();
    chk_bcast("single_t1", 2);
    req = 4'b0000;
    tick();
    chk_state("single_idle", RA_IDLE);
    chk_gnt("single_idle", 4'b0000);
    chk_valid("single_idle", 1'b0);

    // Wrap from rr_ptr=3: agent 3 first, then agent 0 back-to-back
    req = 4'b1001;
    tick();
    chk_bcast("wrap_a3", 3);
    req = 4'b0001;
    tick();
    chk_bcast("wrap_a0", 0);
    req = 4'b0000;
    tick();
    chk_state("wrap_idle", RA_IDLE);

    // rr_ptr now 1: agent 1 beats agent 0, then agent 0 follows
    req = 4'b0011;
    tick();
    chk_bcast("ptr1_a1", 1);
    req = 4'b0001;
    tick();
    chk_bcast("ptr1_a0", 0);
    req = 4'b0000;
    tick();
    chk_state("ptr1_idle", RA_IDLE);

    // All four from reset, each dropped after its own grant
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    chk_state("all_idle", RA_IDLE);
    tick();
    chk_bcast("all_a0", 0);
    req = 4'b1110;
    tick();
    chk_bcast("all_a1", 1);
    req = 4'b1100;
    tick();
    chk_bcast("all_a2", 2);
    req = 4'b1000;
    tick();
    chk_bcast("all_a3", 3);
    req = 4'b0000;
    tick();
    chk_state("all_idle_end", RA_IDLE);
    chk_valid("all_idle_end", 1'b0);

    // Hold: owner 1 busy for 5 cycles, agent 0 pending
    req = 4'b0010;
    tick();
    chk_bcast("hold_bcast", 1);
    busy = 4'b0010;
    req  = 4'b0001;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_state("hold_busy", RA_HOLD);
      chk_gnt("hold_busy", 4'b0000);
      chk_msg("hold_busy", held(1));
    end
    tick();
    busy = 4'b0000;
    chk_state("hold_last", RA_HOLD);
    chk_gnt("hold_last", 4'b0000);
    tick();
    chk_state("hold_release", RA_IDLE);
    chk_gnt("hold_release", 4'b0000);
    tick();
    chk_bcast("hold_next_a0", 0);
    // Non-owner busy must not cause a hold
    busy = 4'b0100;
    req  = 4'b0000;
    tick();
    chk_state("nonowner_busy", RA_IDLE);
    busy = 4'b0000;

    // Timeout: busy[0] stuck, agent 2 pending
    req = 4'b0001;
    tick();
    chk_bcast("to_bcast", 0);
    busy = 4'b0001;
    req  = 4'b0100;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk_state("to_hold", RA_HOLD);
      chk_to("to_hold", 1'b0);
    end
    tick();
    chk_state("to_fire", RA_HOLD);
    chk_to("to_fire", 1'b1);
    chk_valid("to_fire", 1'b0);
    tick();
    chk_state("to_idle", RA_IDLE);
    chk_to("to_idle", 1'b0);
    tick();
    chk_bcast("to_next_a2", 2);
    busy = 4'b0000;
    req  = 4'b0000;
    tick();
    chk_state("to_end", RA_IDLE);

    // Reset during HOLD (rr_ptr would be 2 without the reset)
    req = 4'b0010;
    tick();
    chk_bcast("rst_bcast", 1);
    busy = 4'b0010;
    req  = 4'b0000;
    tick();
    chk_state("rst_hold", RA_HOLD);
    rst = 1'b1;
    tick();
    chk_gnt("rst_mid", 4'b0000);
    chk_msg("rst_mid", '0);
    chk_owner("rst_mid", 2'd0);
    chk_state("rst_mid", RA_IDLE);
    rst  = 1'b0;
    busy = 4'b0000;
    req  = 4'b0110;
    tick();
    chk_bcast("rst_after_a1", 1);
    req = 4'b0100;
    tick();
    chk_bcast("rst_after_a2", 2);
    req = 4'b0000;
    tick();
    chk_state("final_idle", RA_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
